// File: rtl/fetch_issue.sv
// Instruction fetch and issue stage: holds the PC, fetches one word at a time
// from a variable-latency instruction memory and offers it to decode over a
// valid/ready handshake. Taken-branch redirects from execute discard wrong-path work.
module fetch_issue #(
   parameter int unsigned     PC_W     = 8,
   parameter int unsigned     INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(0)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic [INSTR_W-1:0] issue_instr,
   output logic [3:0]         issue_opcode,
   output logic [PC_W-1:0]    issue_pc,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target
);

   localparam int unsigned OPC_W = 4;

   // FETCH: may request; WAIT: response pending for a live request;
   // DRAIN: response pending for a squashed request; ISSUE: word held for decode
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2,
      S_ISSUE = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [PC_W-1:0]      ipc_q, ipc_d;

   // Next-state logic and the two handshake strobes; a redirect beats every other event
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      // rst_n gate keeps the request low while reset is held with run=1
      imem_req    = rst_n & (state_q == S_FETCH) & run & ~branch_taken;
      issue_valid = (state_q == S_ISSUE) & ~branch_taken;

      unique case (state_q)
         S_FETCH: begin
            if (branch_taken) begin
               pc_d = branch_target;
            end else if (run) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (branch_taken) begin
               pc_d    = branch_target;
               state_d = imem_valid ? S_FETCH : S_DRAIN;
            end else if (imem_valid) begin
               instr_d = imem_rdata;
               ipc_d   = pc_q;
               state_d = S_ISSUE;
            end
         end
         S_DRAIN: begin
            // The orphaned response always retires the outstanding request,
            // even when a new redirect lands in the same cycle.
            if (branch_taken) begin
               pc_d = branch_target;
            end
            if (imem_valid) begin
               state_d = S_FETCH;
            end
         end
         S_ISSUE: begin
            if (branch_taken) begin
               pc_d    = branch_target;
               state_d = S_FETCH;
            end else if (issue_ready) begin
               pc_d    = pc_q + PC_W'(1);
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // State, PC and held-instruction registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= INSTR_W'(0);
         ipc_q   <= PC_W'(0);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
      end
   end

   assign imem_addr    = pc_q;
   assign issue_instr  = instr_q;
   assign issue_pc     = ipc_q;
   assign issue_opcode = instr_q[INSTR_W-1 -: OPC_W];

endmodule

// File: tb/tb_fetch_issue.sv
// Bench for fetch_issue: directed per-cycle vector table, a reset-in-flight
// sequence, then randomized traffic against a transaction-level reference model.
module tb_fetch_issue;

   localparam int unsigned PC_W    = 8;
   localparam int unsigned INSTR_W = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               run;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_valid;
   logic [INSTR_W-1:0] imem_rdata;
   logic               issue_valid;
   logic               issue_ready;
   logic [INSTR_W-1:0] issue_instr;
   logic [3:0]         issue_opcode;
   logic [PC_W-1:0]    issue_pc;
   logic               branch_taken;
   logic [PC_W-1:0]    branch_target;

   always #5 clk = ~clk;

   fetch_issue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_instr(issue_instr), .issue_opcode(issue_opcode), .issue_pc(issue_pc),
      .branch_taken(branch_taken), .branch_target(branch_target)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic               run;
      logic               iv;
      logic [INSTR_W-1:0] rdata;
      logic               rdy;
      logic               bt;
      logic [PC_W-1:0]    tgt;
      logic               e_req;
      logic [PC_W-1:0]    e_addr;
      logic               e_valid;
      logic [INSTR_W-1:0] e_instr;
      logic [PC_W-1:0]    e_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int r, int iv, int rd, int rdy, int bt, int tgt,
                               int ereq, int eaddr, int ev, int ei, int ep);
      vec_t v;
      v.run = 1'(r);   v.iv = 1'(iv);   v.rdata = 16'(rd); v.rdy = 1'(rdy);
      v.bt  = 1'(bt);  v.tgt = 8'(tgt); v.e_req = 1'(ereq); v.e_addr = 8'(eaddr);
      v.e_valid = 1'(ev); v.e_instr = 16'(ei); v.e_pc = 8'(ep);
      return v;
   endfunction

   task automatic idle_inputs();
      run = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
      issue_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model: request/response bookkeeping over the spec's rules
   logic [INSTR_W-1:0] mem [256];
   logic [PC_W-1:0]    m_pc, m_ipc, resp_addr;
   logic [INSTR_W-1:0] m_instr;
   bit                 m_out, m_wrong, m_held, pend, m_can_req;
   int                 cnt;

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

      // ---- reset values ----
      #12;
      chk("rst req",   imem_req,    1'b0);
      chk("rst valid", issue_valid, 1'b0);
      chk("rst instr", issue_instr, 16'h0);
      chk("rst pc",    issue_pc,    8'h0);
      chk("rst addr",  imem_addr,   8'h0);
      do_reset();

      // ---- directed vector table ----
      vecs.push_back(mk(0,0,0,0,0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,       1,0,0,0,0));
      vecs.push_back(mk(1,1,'h1234,0,0,0,  0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,       0,0,1,'h1234,0));
      vecs.push_back(mk(1,0,0,1,0,0,       1,1,0,0,0));
      vecs.push_back(mk(1,1,'h2345,1,0,0,  0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,       0,0,1,'h2345,1));
      vecs.push_back(mk(1,0,0,1,0,0,       1,2,0,0,0));
      vecs.push_back(mk(1,1,'h3456,1,0,0,  0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,       0,0,1,'h3456,2));
      vecs.push_back(mk(1,0,0,0,0,0,       1,3,0,0,0));
      vecs.push_back(mk(1,1,'h4ABC,0,0,0,  0,0,0,0,0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1,0,0,0,0,0,    0,0,1,'h4ABC,3));
      vecs.push_back(mk(1,0,0,1,0,0,       0,0,1,'h4ABC,3));
      vecs.push_back(mk(1,0,0,0,0,0,       1,4,0,0,0));
      vecs.push_back(mk(1,0,0,0,1,'h40,    0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,1,'h50,    0,0,0,0,0));
      vecs.push_back(mk(1,1,'hFFFF,0,0,0,  0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,       1,'h50,0,0,0));
      vecs.push_back(mk(1,1,'h7777,1,0,0,  0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,1,'h10,    0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,       1,'h10,0,0,0));
      vecs.push_back(mk(1,1,'hBEEF,1,1,'hFF, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,       1,'hFF,0,0,0));
      vecs.push_back(mk(1,1,'h9ABC,1,0,0,  0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,       0,0,1,'h9ABC,'hFF));
      vecs.push_back(mk(1,0,0,1,0,0,       1,0,0,0,0));
      vecs.push_back(mk(1,1,'h0123,1,0,0,  0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,       0,0,1,'h0123,0));
      vecs.push_back(mk(1,0,0,1,1,'h20,    0,0,0,0,0));
      vecs.push_back(mk(0,0,0,1,0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,       1,'h20,0,0,0));

      foreach (vecs[i]) begin
         @(negedge clk);
         run = vecs[i].run; imem_valid = vecs[i].iv; imem_rdata = vecs[i].rdata;
         issue_ready = vecs[i].rdy; branch_taken = vecs[i].bt; branch_target = vecs[i].tgt;
         #1;
         chk($sformatf("v%0d req", i), imem_req, vecs[i].e_req);
         if (vecs[i].e_req) chk($sformatf("v%0d addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d valid", i), issue_valid, vecs[i].e_valid);
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d instr", i), issue_instr, vecs[i].e_instr);
            chk($sformatf("v%0d opcode", i), issue_opcode, 4'(vecs[i].e_instr >> 12));
            chk($sformatf("v%0d pc", i), issue_pc, vecs[i].e_pc);
         end
      end

      // ---- reset asserted while in WAIT, late response afterwards ----
      @(negedge clk);
      idle_inputs(); run = 1'b1; rst_n = 1'b0;
      #1;
      chk("midrst req",   imem_req,    1'b0);
      chk("midrst valid", issue_valid, 1'b0);
      chk("midrst instr", issue_instr, 16'h0);
      chk("midrst pc",    issue_pc,    8'h0);
      chk("midrst addr",  imem_addr,   8'h0);
      @(negedge clk);
      imem_valid = 1'b1; imem_rdata = 16'hDEAD;
      @(negedge clk);
      rst_n = 1'b1; run = 1'b0; imem_valid = 1'b1; imem_rdata = 16'hDEAD;
      #1;
      chk("late req",   imem_req,    1'b0);
      chk("late valid", issue_valid, 1'b0);
      @(negedge clk);
      imem_valid = 1'b0; run = 1'b1;
      #1;
      chk("post req",   imem_req,  1'b1);
      chk("post addr",  imem_addr, 8'h00);
      @(negedge clk);
      imem_valid = 1'b1; imem_rdata = 16'h5555;
      #1;
      chk("post wait valid", issue_valid, 1'b0);
      @(negedge clk);
      imem_valid = 1'b0; issue_ready = 1'b0;
      #1;
      chk("post valid", issue_valid, 1'b1);
      chk("post instr", issue_instr, 16'h5555);
      chk("post pc",    issue_pc,    8'h00);

      // ---- randomized traffic vs reference model ----
      do_reset();
      m_pc = 8'h00; m_out = 0; m_wrong = 0; m_held = 0; pend = 0; cnt = 0;
      m_instr = '0; m_ipc = '0; resp_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         run           = ($urandom_range(0, 7) != 0);
         issue_ready   = ($urandom_range(0, 2) != 0);
         branch_taken  = ($urandom_range(0, 11) == 0);
         branch_target = 8'($urandom);
         if (pend) begin
            imem_valid = (cnt == 0);
            imem_rdata = mem[resp_addr];
         end else begin
            imem_valid = ($urandom_range(0, 15) == 0);
            imem_rdata = 16'($urandom);
         end
         #1;
         m_can_req = !m_out && !m_held && run && !branch_taken;
         chk("rnd req", imem_req, m_can_req);
         if (m_can_req) chk("rnd addr", imem_addr, m_pc);
         chk("rnd valid", issue_valid, m_held && !branch_taken);
         if (m_held && !branch_taken) begin
            chk("rnd instr", issue_instr, m_instr);
            chk("rnd pc",    issue_pc,    m_ipc);
         end

         // memory stub follows the DUT's strobes
         if (pend && imem_valid) pend = 0;
         else if (pend) cnt--;
         if (imem_req) begin
            pend = 1; cnt = $urandom_range(0, 3); resp_addr = imem_addr;
         end

         // model update
         if (branch_taken) begin
            m_pc   = branch_target;
            m_held = 0;
            if (m_out) begin
               if (imem_valid) begin m_out = 0; m_wrong = 0; end
               else m_wrong = 1;
            end
         end else if (m_held) begin
            if (issue_ready) begin m_held = 0; m_pc = m_pc + 8'd1; end
         end else if (m_out) begin
            if (imem_valid) begin
               if (!m_wrong) begin m_held = 1; m_instr = imem_rdata; m_ipc = m_pc; end
               m_out = 0; m_wrong = 0;
            end
         end else if (run) begin
            m_out = 1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_issue.md
Name: fetch_issue

Overview:
- Instruction fetch and issue stage: the producer end of the opcode interface that the control decoder consumes.
- Holds the PC and requests 16-bit instruction words from instruction memory over a variable-latency request/response interface.
- Presents each fetched word, its opcode field and its PC to decode over a valid/ready handshake.
- Redirects the PC when execute resolves a taken BEZ, discarding wrong-path work.

Parameters:
PC_W, 8, PC/instruction-memory address width in words
INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = new fetches may start; 0 = no new request issued (in-flight work completes)
imem_req  out  1  single-cycle request strobe
imem_addr  out  PC_W  request address, valid while imem_req=1
imem_valid  in  1  response strobe, >=1 cycle after accepted imem_req
imem_rdata  in  INSTR_W  response data, valid with imem_valid
issue_valid  out  1  instruction available to decode
issue_ready  in  1  decode accepts this cycle
issue_instr  out  INSTR_W  held instruction word
issue_opcode  out  4  issue_instr[INSTR_W-1:INSTR_W-4]
issue_pc  out  PC_W  address of issue_instr
branch_taken  in  1  taken-branch redirect pulse from execute
branch_target  in  PC_W  redirect address, valid with branch_taken

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=FETCH.
  - issue_instr=0, issue_pc=0.
  - imem_req=0, issue_valid=0.
- Protocol limits: at most one outstanding memory request; imem_valid with no outstanding request is ignored.
- FETCH:
  - imem_req = run & ~branch_taken; imem_addr=pc.
  - On imem_req=1, go to WAIT.
  - On branch_taken: pc<=branch_target, stay FETCH, no request issued that cycle.
- WAIT:
  - On imem_valid & ~branch_taken: capture issue_instr<=imem_rdata, issue_pc<=pc; go to ISSUE.
  - On branch_taken: pc<=branch_target.
    - If imem_valid the same cycle, discard the data and go to FETCH.
    - Otherwise go to DRAIN.
- DRAIN:
  - Waits for the orphaned response; on imem_valid, discard it and go to FETCH.
  - branch_taken here: pc<=branch_target, stay DRAIN (last target wins).
- ISSUE:
  - issue_valid = ~branch_taken (combinational gate).
  - On issue_valid & issue_ready: pc<=pc+1 (mod 2^PC_W, PC_W'(2^PC_W-1)+1 wraps to 0); go to FETCH.
  - On branch_taken: no transfer regardless of issue_ready; pc<=branch_target; held instruction dropped; go to FETCH.
  - issue_instr and issue_pc stay stable while issue_valid=1 and ~issue_ready.
- Priority: branch_taken overrides every other event in every state.
- issue_opcode is a pure slice of issue_instr; no decoding here. Opcode 0000 (NOP) is issued like any other.
- Timing:
  - Zero-latency memory impossible; minimum cadence with 1-cycle memory and issue_ready=1 is 3 cycles/instruction (FETCH, WAIT, ISSUE).
  - Request to issue_valid latency = memory latency + 1.
- run=0:
  - Blocks only the FETCH-state request; WAIT, DRAIN and ISSUE proceed.
  - Branch redirects still update pc.
- Reset mid-operation: all state returns to reset values immediately. Memory responses arriving after reset with no outstanding request are ignored.
- No X on any output after reset.

Test Plan:
- Sequential fetch: RESET_PC=0, 1-cycle memory returning words 0x1234,0x2345,0x3456, issue_ready=1 -> imem_addr 0,1,2 one request every 3 cycles; issue_opcode 1,2,3; issue_pc 0,1,2.
- Backpressure: issue_ready=0 for 5 cycles with 0x4ABC held -> issue_valid=1, issue_instr=0x4ABC, issue_pc constant, no imem_req; pc increments by exactly 1 after ready rises.
- Redirect in WAIT: 4-cycle memory, branch_taken with target 0x40 one cycle after request -> DRAIN, orphaned response discarded (issue_valid stays 0), next imem_addr=0x40; second branch in DRAIN with target 0x50 -> next imem_addr=0x50.
- Redirect in ISSUE with issue_ready=1 same cycle: target 0x10 -> issue_valid=0 that cycle, no transfer counted, next imem_addr=0x10.
- Wrap: PC_W=8, branch to 0xFF, fetch and issue that word -> next imem_addr=0x00.
- run/reset: run=0 after reset -> imem_req stays 0. Raise run and assert rst_n=0 during WAIT -> outputs return to reset values at once; late imem_valid ignored; first request after release is at RESET_PC.
